// File: rtl/uart_tx_fifo_if.sv
// Byte-push / status bundle between the CPU store path and the buffered
// UART transmitter. The CPU side is the master; the transmitter is the slave.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_ovf;
    logic          tx;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          busy;
    logic          overflow;

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  tx, full, empty, level, busy, overflow
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output tx, full, empty, level, busy, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Stores to the UART address push bytes into
// a circular FIFO; a four-state framer drains it onto the serial line at a
// fixed bit period with no idle gap between queued frames. All outputs,
// including the status flags, come straight from flops.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BAUD_ZERO  = BW'(0);
    localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PTR_ZERO   = PW'(0);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Framer state
    state_e        state_q,  state_d;
    logic [BW-1:0] baud_q,   baud_d;
    logic [2:0]    bitidx_q, bitidx_d;
    logic [7:0]    shreg_q,  shreg_d;
    logic          tx_q,     tx_d;

    // FIFO state
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wp_q,     wp_d;
    logic [PW-1:0] rp_q,     rp_d;
    logic [LW-1:0] level_q,  level_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          busy_q,   busy_d;
    logic          ovf_q,    ovf_d;

    // Per-cycle strobes
    logic          push_s;
    logic          drop_s;
    logic          pop_s;
    logic          bit_end_s;
    logic [7:0]    head_s;

    // Write qualification against the pre-edge full flag, and baud tick.
    always_comb begin
        push_s    = bus.wr_en & ~full_q;
        drop_s    = bus.wr_en &  full_q;
        bit_end_s = (baud_q == BAUD_LAST);
        head_s    = mem_q[rp_q];
    end

    // Framer next-state: start bit, 8 data bits LSB first, stop bit, and a
    // back-to-back reload at the end of STOP when more bytes are waiting.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bitidx_d = bitidx_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        pop_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = BAUD_ZERO;
                if (!empty_q) begin
                    pop_s   = 1'b1;
                    shreg_d = head_s;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_d   = BAUD_ZERO;
                    tx_d     = shreg_q[0];
                    bitidx_d = 3'd0;
                    state_d  = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_d = BAUD_ZERO;
                    if (bitidx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // The next bit to drive is the one above the current LSB.
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        tx_d     = shreg_q[1];
                        bitidx_d = bitidx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_d = BAUD_ZERO;
                    if (!empty_q) begin
                        // Reload directly so the next start bit follows with no gap.
                        pop_s   = 1'b1;
                        shreg_d = head_s;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = BAUD_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: pointers, occupancy, status flags and sticky overflow.
    always_comb begin
        if (push_s) begin
            wp_d = wp_q + PTR_ONE;
        end else begin
            wp_d = wp_q;
        end

        if (pop_s) begin
            rp_d = rp_q + PTR_ONE;
        end else begin
            rp_d = rp_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        full_d  = (level_d == LEVEL_FULL);
        empty_d = (level_d == LEVEL_ZERO);
        busy_d  = (level_d != LEVEL_ZERO) || (state_d != ST_IDLE);

        // A dropped write in the same cycle as a clear leaves the flag set.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wp_q] <= bus.wr_data;
        end
    end

    // State registers with synchronous reset; a reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= BAUD_ZERO;
            bitidx_q <= 3'd0;
            shreg_q  <= 8'h00;
            tx_q     <= 1'b1;
            wp_q     <= PTR_ZERO;
            rp_q     <= PTR_ZERO;
            level_q  <= LEVEL_ZERO;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitidx_q <= bitidx_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.level    = level_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH=4.
// A serial receiver decodes the line and pops a scoreboard of expected bytes.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         rx_count = 0;
    logic       rx_abort = 1'b1;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       clr_ovf;
        logic       push_exp;
        logic [2:0] level;
        logic       full;
        logic       empty;
        logic       busy;
        logic       ovf;
        logic       tx;
    } vec_t;

    vec_t vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic expect_accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (expect_accept) exp_q.push_back(b);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 32'(bus.busy), 32'd0);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic exp_tx_at(input int e, input logic [7:0] b);
        if (e < 1)        return 1'b1;
        else if (e <= 4)  return 1'b0;
        else if (e <= 36) return b[(e - 5) / 4];
        else              return 1'b1;
    endfunction

    // Line receiver: t=0 is the first negedge seeing the start bit; bit k is sampled at t=4k+2.
    initial begin
        int         rx_phase = 0;
        int         rx_t = 0;
        logic [7:0] rx_byte = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rx_abort) begin
                rx_phase = 0;
            end else if (rx_phase == 0) begin
                if (bus.tx === 1'b0) begin
                    rx_phase = 1;
                    rx_t     = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                rx_t++;
                if (rx_t == 2) begin
                    check("rx_start_bit", 32'(bus.tx), 32'd0);
                end else if (rx_t >= 6 && rx_t <= 34 && ((rx_t - 2) % 4) == 0) begin
                    rx_byte[(rx_t - 6) / 4] = bus.tx;
                end else if (rx_t == 38) begin
                    check("rx_stop_bit", 32'(bus.tx), 32'd1);
                    rx_count++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected: received 0x%0h, no byte expected (cycle %0d)", rx_byte, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_byte", 32'(rx_byte), 32'(e));
                    end
                    rx_phase = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         peak;
        int         diff;
        int         rx_base;
        int         n;
        logic [7:0] b;

        // Overflow table: 6 back-to-back writes, then clear / set-wins checks.
        //           wr    data   clr   push  lvl   full  empty busy  ovf   tx
        vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h66, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 8'h77, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_ovf = 1'b0;
        @(negedge clk);
        tick();
        tick();

        // Reset state
        check("rst_tx",    32'(bus.tx),       32'd1);
        check("rst_full",  32'(bus.full),     32'd0);
        check("rst_empty", 32'(bus.empty),    32'd1);
        check("rst_level", 32'(bus.level),    32'd0);
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_ovf",   32'(bus.overflow), 32'd0);
        rst      = 1'b0;
        rx_abort = 1'b0;
        tick();

        // Single byte 0x55: exact line waveform and status per edge
        b = 8'h55;
        write_byte(b, 1'b1);
        for (int e = 0; e <= 41; e++) begin
            if (e > 0) tick();
            check($sformatf("single_tx_e%0d", e), 32'(bus.tx), 32'(exp_tx_at(e, b)));
            check($sformatf("single_busy_e%0d", e), 32'(bus.busy), (e <= 40) ? 32'd1 : 32'd0);
            if (e <= 1) begin
                check($sformatf("single_level_e%0d", e), 32'(bus.level), (e == 0) ? 32'd1 : 32'd0);
                check($sformatf("single_empty_e%0d", e), 32'(bus.empty), (e == 0) ? 32'd0 : 32'd1);
            end
        end
        check("single_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Back-to-back pair: no gap, frame 2 starts 40 cycles after frame 1
        start_q.delete();
        peak = 0;
        write_byte(8'hA3, 1'b1);
        if (int'(bus.level) > peak) peak = int'(bus.level);
        write_byte(8'h0F, 1'b1);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            if (int'(bus.level) > peak) peak = int'(bus.level);
            tick();
            n++;
        end
        check("pair_idle", 32'(bus.busy), 32'd0);
        check("pair_level_peak", 32'(peak), 32'd1);
        check("pair_frames", 32'(start_q.size()), 32'd2);
        diff = (start_q.size() >= 2) ? (start_q[1] - start_q[0]) : -1;
        check("pair_start_gap", 32'(diff), 32'd40);
        check("pair_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Overflow table
        for (int i = 0; i < 10; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_data = vecs[i].wr_data;
            bus.clr_ovf = vecs[i].clr_ovf;
            if (vecs[i].push_exp) exp_q.push_back(vecs[i].wr_data);
            tick();
            check($sformatf("vec%0d_level", i), 32'(bus.level),    32'(vecs[i].level));
            check($sformatf("vec%0d_full", i),  32'(bus.full),     32'(vecs[i].full));
            check($sformatf("vec%0d_empty", i), 32'(bus.empty),    32'(vecs[i].empty));
            check($sformatf("vec%0d_busy", i),  32'(bus.busy),     32'(vecs[i].busy));
            check($sformatf("vec%0d_ovf", i),   32'(bus.overflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_tx", i),    32'(bus.tx),       32'(vecs[i].tx));
        end
        bus.wr_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        wait_idle("ovf", 400);
        tick();

        // Full FIFO plus a write on the cycle STOP ends: pop happens, write dropped
        write_byte(8'hC1, 1'b1);
        write_byte(8'hC2, 1'b1);
        write_byte(8'hC3, 1'b1);
        write_byte(8'hC4, 1'b1);
        write_byte(8'hC5, 1'b1);
        repeat (36) tick();
        check("fp_pre_level", 32'(bus.level), 32'd4);
        check("fp_pre_full",  32'(bus.full),  32'd1);
        write_byte(8'hEE, 1'b0);
        check("fp_level",  32'(bus.level),    32'd3);
        check("fp_full",   32'(bus.full),     32'd0);
        check("fp_ovf",    32'(bus.overflow), 32'd1);
        check("fp_tx",     32'(bus.tx),       32'd0);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("fp_ovf_clr", 32'(bus.overflow), 32'd0);
        wait_idle("fp", 400);
        tick();

        // Reset during DATA bit 3 with two bytes queued
        write_byte(8'hD1, 1'b1);
        write_byte(8'hD2, 1'b1);
        write_byte(8'hD3, 1'b1);
        repeat (16) tick();
        check("mrst_pre_level", 32'(bus.level), 32'd2);
        rst      = 1'b1;
        rx_abort = 1'b1;
        tick();
        check("mrst_tx",    32'(bus.tx),    32'd1);
        check("mrst_level", 32'(bus.level), 32'd0);
        check("mrst_empty", 32'(bus.empty), 32'd1);
        check("mrst_busy",  32'(bus.busy),  32'd0);
        tick();
        rst      = 1'b0;
        rx_abort = 1'b0;
        exp_q.delete();
        start_q.delete();
        repeat (60) tick();
        check("mrst_no_frames", 32'(start_q.size()), 32'd0);
        check("mrst_idle_tx",   32'(bus.tx),         32'd1);
        check("mrst_idle_busy", 32'(bus.busy),       32'd0);

        // Wrap-around: 3*DEPTH random bytes, throttled on full
        rx_base = rx_count;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            n = 0;
            while (bus.full === 1'b1 && n < 200) begin
                tick();
                n++;
            end
            check("wrap_throttle", 32'(bus.full), 32'd0);
            write_byte(8'($urandom_range(0, 255)), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle("wrap", 1000);
        check("wrap_rx_count", 32'(rx_count - rx_base), 32'(3 * DEPTH));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
